// File: rtl/demapper_ber_checker.sv
// demapper_ber_checker: per-frame bit/symbol error checker for demapper output.
// Hard-decides each LLR lane, compares the active lanes against a locally
// regenerated reference (symbol index counter, or PRBS-15 when the macro
// DEMAPPER_BER_CHECKER_PRBS_EN is defined) and reports per-frame error counts.
// Pipeline: S0 decision/compare, S1 registered masked XOR, S2 accumulate/report.
module demapper_ber_checker #(
  parameter int pLLR_W    = 4,
  parameter int pBITS_MAX = 10,
  parameter int pCNT_W    = 16
) (
  input  logic                          iclk,
  input  logic                          ireset,
  input  logic                          iclkena,
  input  logic                          ival,
  input  logic                          isop,
  input  logic [3:0]                    iqam,
  input  logic                          imode,
  input  logic [pBITS_MAX*pLLR_W-1:0]   iLLR,
  output logic                          oframe_done,
  output logic [3:0]                    oframe_qam,
  output logic                          oabort,
  output logic [pCNT_W-1:0]             obit_err,
  output logic [pCNT_W-1:0]             osym_err,
  output logic [pCNT_W-1:0]             osym_cnt,
  output logic                          oqam_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0]               QAM_MAX  = 4'(pBITS_MAX);
  localparam logic signed [pLLR_W-1:0] LLR_ZERO = '0;
  localparam logic [14:0]              PRBS_SEED = 15'h7FFF;
  localparam logic [pCNT_W-1:0]        CNT_ONE  = {{(pCNT_W-1){1'b0}}, 1'b1};

  // Lane mask with the low q bits set.
  function automatic logic [pBITS_MAX-1:0] mask_of(input logic [3:0] q);
    logic [pBITS_MAX:0] one;
    logic [pBITS_MAX:0] t;
    one = {{pBITS_MAX{1'b0}}, 1'b1};
    t   = (one << q) - 1'b1;
    return t[pBITS_MAX-1:0];
  endfunction

  // Number of set bits in an error vector.
  function automatic logic [4:0] popcount(input logic [pBITS_MAX-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < pBITS_MAX; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

  // Unsigned add that clamps at the all-ones counter value.
  function automatic logic [pCNT_W-1:0] sat_add(input logic [pCNT_W-1:0] a,
                                                input logic [pCNT_W-1:0] b);
    logic [pCNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[pCNT_W] ? {pCNT_W{1'b1}} : s[pCNT_W-1:0];
  endfunction

  // One step of the x^15+x^14+1 Fibonacci LFSR.
  function automatic logic [14:0] prbs_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  // Frame control state
  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_qam;
  logic [pBITS_MAX-1:0] r_idx;
  logic                 r_qam_err;

  // S0 signals
  logic                 w_legal;
  logic                 w_run;
  logic                 w_start;
  logic                 w_cont;
  logic                 w_acc;
  logic                 w_abort;
  logic                 w_last;
  logic [3:0]           w_qam_use;
  logic [pBITS_MAX-1:0] w_idx_use;
  logic [pBITS_MAX-1:0] w_mask;
  logic [pBITS_MAX-1:0] w_ref;
  logic [pBITS_MAX-1:0] w_dec;
  logic [pBITS_MAX-1:0] w_xor;

  // S1 registers
  logic                 r_vld_p1;
  logic                 r_first_p1;
  logic                 r_last_p1;
  logic                 r_abort_p1;
  logic [3:0]           r_qam_p1;
  logic [pBITS_MAX-1:0] r_xor_p1;

  // S2 accumulators and report registers
  logic [pCNT_W-1:0]    r_bit_acc;
  logic [pCNT_W-1:0]    r_sym_acc;
  logic [pCNT_W-1:0]    r_cnt_acc;
  logic [3:0]           r_acc_qam;
  logic                 r_done;
  logic [3:0]           r_rep_qam;
  logic                 r_rep_abort;
  logic [pCNT_W-1:0]    r_rep_bit;
  logic [pCNT_W-1:0]    r_rep_sym;
  logic [pCNT_W-1:0]    r_rep_cnt;

  logic [pCNT_W-1:0]    w_bit_add;
  logic [pCNT_W-1:0]    w_sym_add;
  logic [pCNT_W-1:0]    w_bit_sum;
  logic [pCNT_W-1:0]    w_sym_sum;
  logic [pCNT_W-1:0]    w_cnt_sum;

  assign w_legal   = (iqam != 4'd0) && (iqam <= QAM_MAX);
  assign w_run     = (r_state == RUN);
  assign w_start   = ival & isop & w_legal;
  assign w_cont    = ival & ~isop & w_run;
  assign w_acc     = w_start | w_cont;
  assign w_abort   = ival & isop & w_run;
  assign w_qam_use = w_start ? iqam : r_qam;
  assign w_idx_use = w_start ? '0 : r_idx;
  assign w_mask    = mask_of(w_qam_use);
  assign w_last    = w_cont & (w_idx_use == w_mask);

`ifdef DEMAPPER_BER_CHECKER_PRBS_EN
  logic [14:0] r_prbs;
  logic        r_mode;
  logic [14:0] w_prbs_use;
  logic        w_mode_use;

  assign w_prbs_use = w_start ? PRBS_SEED : r_prbs;
  assign w_mode_use = w_start ? imode : r_mode;
  assign w_ref      = w_mode_use ? w_prbs_use[pBITS_MAX-1:0] : w_idx_use;

  // PRBS state and mode: seeded at frame start, advanced after each symbol uses it
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_prbs <= PRBS_SEED;
      r_mode <= 1'b0;
    end else if (iclkena && w_acc) begin
      r_prbs <= prbs_step(w_prbs_use);
      r_mode <= w_mode_use;
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = imode;
  assign w_ref         = w_idx_use;
`endif

  // Hard decision per lane: non-negative LLR decides 1
  always_comb begin
    logic signed [pLLR_W-1:0] v_lane;
    v_lane = '0;
    w_dec  = '0;
    for (int i = 0; i < pBITS_MAX; i++) begin
      v_lane   = iLLR[i*pLLR_W +: pLLR_W];
      w_dec[i] = (v_lane >= LLR_ZERO);
    end
  end

  assign w_xor = (w_dec ^ w_ref) & w_mask;

  // FSM next state: any isop restarts or parks the FSM, the last symbol ends the frame
  always_comb begin
    w_state_nxt = r_state;
    if (ival && isop) begin
      w_state_nxt = w_legal ? RUN : IDLE;
    end else if (w_last) begin
      w_state_nxt = IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= IDLE;
    end else if (iclkena) begin
      r_state <= w_state_nxt;
    end
  end

  // Frame qam and symbol index, latched at frame start and stepped per symbol
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_qam <= 4'd0;
      r_idx <= '0;
    end else if (iclkena && w_acc) begin
      r_qam <= w_qam_use;
      r_idx <= w_idx_use + 1'b1;
    end
  end

  // Sticky illegal-qam flag
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_qam_err <= 1'b0;
    end else if (iclkena && ival && isop && !w_legal) begin
      r_qam_err <= 1'b1;
    end
  end

  // ---- S0 -> S1 ----
  // Control side of S1
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
      r_last_p1  <= 1'b0;
      r_abort_p1 <= 1'b0;
      r_qam_p1   <= 4'd0;
    end else if (iclkena) begin
      r_vld_p1   <= w_acc;
      r_first_p1 <= w_start;
      r_last_p1  <= w_last;
      r_abort_p1 <= w_abort;
      r_qam_p1   <= w_qam_use;
    end
  end

  // Data side of S1: masked error vector
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      r_xor_p1 <= w_xor;
    end
  end

  // ---- S1 -> S2 ----
  assign w_bit_add = pCNT_W'(popcount(r_xor_p1));
  assign w_sym_add = {{(pCNT_W-1){1'b0}}, |r_xor_p1};
  assign w_bit_sum = sat_add(r_bit_acc, w_bit_add);
  assign w_sym_sum = sat_add(r_sym_acc, w_sym_add);
  assign w_cnt_sum = sat_add(r_cnt_acc, CNT_ONE);

  // Accumulate, and report either the finished frame or the frame cut short
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_bit_acc   <= '0;
      r_sym_acc   <= '0;
      r_cnt_acc   <= '0;
      r_acc_qam   <= 4'd0;
      r_done      <= 1'b0;
      r_rep_qam   <= 4'd0;
      r_rep_abort <= 1'b0;
      r_rep_bit   <= '0;
      r_rep_sym   <= '0;
      r_rep_cnt   <= '0;
    end else if (iclkena) begin
      r_done <= 1'b0;
      if (r_abort_p1) begin
        r_done      <= 1'b1;
        r_rep_qam   <= r_acc_qam;
        r_rep_abort <= 1'b1;
        r_rep_bit   <= r_bit_acc;
        r_rep_sym   <= r_sym_acc;
        r_rep_cnt   <= r_cnt_acc;
      end else if (r_vld_p1 && r_last_p1) begin
        r_done      <= 1'b1;
        r_rep_qam   <= r_qam_p1;
        r_rep_abort <= 1'b0;
        r_rep_bit   <= w_bit_sum;
        r_rep_sym   <= w_sym_sum;
        r_rep_cnt   <= w_cnt_sum;
      end
      if (r_vld_p1) begin
        if (r_first_p1) begin
          r_bit_acc <= w_bit_add;
          r_sym_acc <= w_sym_add;
          r_cnt_acc <= CNT_ONE;
          r_acc_qam <= r_qam_p1;
        end else begin
          r_bit_acc <= w_bit_sum;
          r_sym_acc <= w_sym_sum;
          r_cnt_acc <= w_cnt_sum;
        end
      end
    end
  end

  assign oframe_done = r_done;
  assign oframe_qam  = r_rep_qam;
  assign oabort      = r_rep_abort;
  assign obit_err    = r_rep_bit;
  assign osym_err    = r_rep_sym;
  assign osym_cnt    = r_rep_cnt;
  assign oqam_err    = r_qam_err;

endmodule

// File: tb/tb_demapper_ber_checker.sv
// Directed bench for demapper_ber_checker. Frame reports are captured on every
// enabled clock with oframe_done high and compared with hand-computed results.
// The PRBS section is built only when DEMAPPER_BER_CHECKER_PRBS_EN is defined.
module tb_demapper_ber_checker;

  localparam int LW = 4;
  localparam int NB = 10;
  localparam int CW = 16;

  logic          iclk = 1'b0;
  logic          ireset;
  logic          iclkena;
  logic          ival;
  logic          isop;
  logic [3:0]    iqam;
  logic          imode;
  logic [NB*LW-1:0] iLLR;
  logic          oframe_done;
  logic [3:0]    oframe_qam;
  logic          oabort;
  logic [CW-1:0] obit_err;
  logic [CW-1:0] osym_err;
  logic [CW-1:0] osym_cnt;
  logic          oqam_err;

  demapper_ber_checker #(.pLLR_W(LW), .pBITS_MAX(NB), .pCNT_W(CW)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop),
    .iqam(iqam), .imode(imode), .iLLR(iLLR), .oframe_done(oframe_done),
    .oframe_qam(oframe_qam), .oabort(oabort), .obit_err(obit_err),
    .osym_err(osym_err), .osym_cnt(osym_cnt), .oqam_err(oqam_err)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int qam;
    int abort;
    int be;
    int se;
    int sc;
  } rep_t;

  rep_t got_q[$];
  rep_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   zlane = -1;

  // Capture each report once per enabled clock it is visible on
  always @(posedge iclk) begin
    rep_t r;
    if (!ireset && iclkena && oframe_done) begin
      r.qam   = int'(oframe_qam);
      r.abort = int'(oabort);
      r.be    = int'(obit_err);
      r.se    = int'(osym_err);
      r.sc    = int'(osym_cnt);
      got_q.push_back(r);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive_llr(input logic [NB-1:0] bits);
    for (int i = 0; i < NB; i++) begin
      if (bits[i]) iLLR[i*LW +: LW] = (i == zlane) ? 4'h0 : 4'h7;
      else         iLLR[i*LW +: LW] = 4'h8;
    end
  endtask

  task automatic send_sym(input logic sop, input logic [3:0] q, input logic [NB-1:0] bits);
    ival = 1'b1;
    isop = sop;
    iqam = q;
    drive_llr(bits);
    cyc();
    ival = 1'b0;
    isop = 1'b0;
  endtask

  task automatic idle(input int n);
    ival = 1'b0;
    isop = 1'b0;
    repeat (n) cyc();
  endtask

  // Error-free decisions for symbol s: index in the active lanes, 1s above
  function automatic logic [NB-1:0] clean(input int s, input int q);
    logic [NB-1:0] m;
    m = NB'((1 << q) - 1);
    return (NB'(s) & m) | ~m;
  endfunction

  task automatic send_frame(input int q, input int n, input int eidx, input logic [NB-1:0] ebits);
    for (int s = 0; s < n; s++) begin
      send_sym(s == 0, 4'(q), clean(s, q) ^ ((s == eidx) ? ebits : '0));
    end
  endtask

  task automatic push_exp(input int q, input int ab, input int be, input int se, input int sc);
    rep_t r;
    r.qam = q; r.abort = ab; r.be = be; r.se = se; r.sc = sc;
    exp_q.push_back(r);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_done"}, oframe_done, 0);
    chk({pfx, "_qam"},  oframe_qam,  0);
    chk({pfx, "_abort"}, oabort,     0);
    chk({pfx, "_bit"},  obit_err,    0);
    chk({pfx, "_sym"},  osym_err,    0);
    chk({pfx, "_cnt"},  osym_cnt,    0);
    chk({pfx, "_qerr"}, oqam_err,    0);
  endtask

  initial begin
    int n0;
    int nmin;
    logic [14:0] st;

    ireset  = 1'b1;
    iclkena = 1'b1;
    ival    = 1'b0;
    isop    = 1'b0;
    iqam    = 4'd0;
    imode   = 1'b0;
    iLLR    = '0;
    repeat (3) cyc();
    chk_zero("rst");
    ireset = 1'b0;
    idle(2);

    // Error-free frames back-to-back, qam 1..8 then 10
    for (int q = 1; q <= 8; q++) begin
      send_frame(q, 1 << q, -1, '0);
      push_exp(q, 0, 0, 0, 1 << q);
    end
    send_frame(10, 1024, -1, '0);
    push_exp(10, 0, 0, 0, 1024);
    chk("lat_done_t1", oframe_done, 0);
    idle(1);
    chk("lat_done_t2", oframe_done, 1);
    chk("lat_cnt", osym_cnt, 1024);
    chk("lat_qam", oframe_qam, 10);
    idle(1);
    chk("lat_done_t3", oframe_done, 0);
    idle(5);
    chk("hold_cnt", osym_cnt, 1024);

    // qam=4, symbol 5 lanes 0,2 flipped, masked lane 7 negative, lane 1 LLR of 0
    zlane = 1;
`ifndef DEMAPPER_BER_CHECKER_PRBS_EN
    imode = 1'b1;
`endif
    send_frame(4, 16, 5, 10'h085);
    push_exp(4, 0, 2, 1, 16);
    idle(4);
    zlane = -1;
    imode = 1'b0;

    // qam=6 cut short after 20 symbols by a qam=3 frame
    send_frame(6, 20, 19, 10'h002);
    send_frame(3, 8, 0, 10'h001);
    push_exp(6, 1, 1, 1, 20);
    push_exp(3, 0, 1, 1, 8);
    idle(4);

    // Illegal qam = 0
    send_sym(1'b1, 4'd0, 10'h3FF);
    for (int s = 1; s < 4; s++) send_sym(1'b0, 4'd0, clean(s, 2));
    idle(4);
    chk("qerr_q0", oqam_err, 1);
    chk("q0_no_report", got_q.size(), exp_q.size());
    ireset = 1'b1;
    cyc();
    ireset = 1'b0;
    chk("qerr_cleared", oqam_err, 0);

    // Illegal qam = 11, then a legal frame
    send_sym(1'b1, 4'd11, 10'h3FF);
    for (int s = 1; s < 4; s++) send_sym(1'b0, 4'd11, clean(s, 2));
    idle(4);
    chk("qerr_q11", oqam_err, 1);
    chk("q11_no_report", got_q.size(), exp_q.size());
    send_frame(2, 4, -1, '0);
    push_exp(2, 0, 0, 0, 4);
    idle(4);

`ifdef DEMAPPER_BER_CHECKER_PRBS_EN
    // PRBS reference, qam=2: matched sequence then one-symbol shift
    imode = 1'b1;
    st = 15'h7FFF;
    for (int s = 0; s < 4; s++) begin
      send_sym(s == 0, 4'd2, {8'hFF, st[1:0]});
      st = {st[13:0], st[14] ^ st[13]};
    end
    push_exp(2, 0, 0, 0, 4);
    idle(4);
    st = 15'h7FFE;
    for (int s = 0; s < 4; s++) begin
      send_sym(s == 0, 4'd2, {8'hFF, st[1:0]});
      st = {st[13:0], st[14] ^ st[13]};
    end
    push_exp(2, 0, 2, 2, 4);
    idle(4);
    imode = 1'b0;
`else
    st = 15'h0;
`endif

    // qam=5 frame with iclkena toggling; disabled cycles carry corrupted symbols
    for (int s = 0; s < 32; s++) begin
      iclkena = 1'b1;
      send_sym(s == 0, 4'd5, clean(s, 5));
      iclkena = 1'b0;
      ival = 1'b1;
      isop = 1'b0;
      drive_llr(~clean(s, 5));
      cyc();
    end
    ival = 1'b0;
    for (int k = 0; k < 6; k++) begin
      iclkena = ~iclkena;
      idle(1);
    end
    iclkena = 1'b1;
    idle(3);
    push_exp(5, 0, 0, 0, 32);
    chk("gated_cnt", osym_cnt, 32);

    // Reset in the middle of a qam=5 frame
    n0 = got_q.size();
    send_frame(5, 10, 3, 10'h001);
    ireset = 1'b1;
    cyc();
    ireset = 1'b0;
    chk_zero("midrst");
    for (int s = 10; s < 15; s++) send_sym(1'b0, 4'd5, clean(s, 5));
    idle(6);
    chk("midrst_no_report", got_q.size(), n0);
    chk("midrst_cnt_after", osym_cnt, 0);

    // Compare captured reports against expectations
    chk("n_reports", got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("rep%0d_qam", i),   got_q[i].qam,   exp_q[i].qam);
      chk($sformatf("rep%0d_abort", i), got_q[i].abort, exp_q[i].abort);
      chk($sformatf("rep%0d_bit", i),   got_q[i].be,    exp_q[i].be);
      chk($sformatf("rep%0d_sym", i),   got_q[i].se,    exp_q[i].se);
      chk($sformatf("rep%0d_cnt", i),   got_q[i].sc,    exp_q[i].sc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demapper_ber_checker.md
# demapper_ber_checker

Synthesizable per-frame bit/symbol error checker that sits at the output of `demapper`. It hard-decides the LLR vector, compares it against a locally regenerated reference pattern (index counter, or optional PRBS), and reports error counts per frame for QAM orders 1..pBITS_MAX. It replaces the behavioural compare loop of the mapper/demapper bench with hardware usable on-board and in regression.

## Interface
- pLLR_W, 4: LLR word width, two's complement.
- pBITS_MAX, 10: LLR lanes and maximum bits per symbol (1..15).
- pCNT_W, 16: width of the error and symbol counters.
- iclk  in  1  clock.
- ireset  in  1  synchronous reset, active-high.
- iclkena  in  1  clock enable; all state holds when low.
- ival  in  1  input symbol valid.
- isop  in  1  first symbol of a frame; qualified by ival.
- iqam  in  4  bits per symbol; sampled with isop&ival.
- imode  in  1  reference select: 0 = index counter, 1 = PRBS.
- iLLR  in  pBITS_MAX x pLLR_W  LLR per bit lane; lane 0 = LSB.
- oframe_done  out  1  one-cycle pulse; frame result valid.
- oframe_qam  out  4  qam of the reported frame.
- oabort  out  1  reported frame was cut short by a new isop.
- obit_err  out  pCNT_W  bit errors in the reported frame.
- osym_err  out  pCNT_W  symbols with at least one bit error.
- osym_cnt  out  pCNT_W  symbols received in the reported frame.
- oqam_err  out  1  sticky; set when a frame starts with illegal qam. Cleared only by reset.

## Operation
- Hard decision: bit[i] = (iLLR[i] >= 0), i.e. the inverted sign bit. Lanes i >= qam are masked out and never counted.
- Frame length is 2**qam symbols, with qam latched at isop&ival. Legal qam is 1..pBITS_MAX.
- On illegal qam: set oqam_err and enter IDLE; symbols are ignored until the next isop.
- States:
  - IDLE → RUN on isop&ival with legal qam.
  - RUN → IDLE after the symbol with index 2**qam-1, which raises oframe_done with oabort=0.
  - RUN with isop&ival (legal qam): report the current frame with oabort=1 and start the new frame in the same cycle. The isop symbol is counted as index 0 of the new frame.
  - ival without isop in IDLE is ignored.
- Reference value, mode 0: symbol index, with the counter reset to 0 at isop and incremented per valid symbol.
- Reference value, mode 1: low qam bits of a PRBS-15 state (x^15+x^14+1).
  - State is seeded to 15'h7FFF at isop and advanced one step per valid symbol after use.
  - imode is latched at isop.
- Pipeline:
  - S1 registers the masked XOR of decision and reference.
  - S2 adds popcount(S1) to the bit-error accumulator, and adds 1 to the symbol-error accumulator when the XOR is nonzero.
- Accumulators saturate at 2**pCNT_W-1. They clear when a frame starts; the clear folds in the first symbol's contribution in the same cycle.
- Outputs obit_err/osym_err/osym_cnt/oframe_qam/oabort are registered. They hold their values until the next oframe_done.

## Timing
- Latency: oframe_done rises 2 enabled cycles after the ival cycle of the last (or aborting) symbol. The reported counts include that last symbol; for an abort, they exclude the new isop symbol.
- Full throughput: one symbol per enabled cycle, with no bubbles needed between frames.
- Back-to-back frames: the next frame's isop may arrive in the cycle right after the last symbol of the previous frame.
- iclkena=0 freezes the pipeline, FSM, PRBS and accumulators. oframe_done is held as-is (a pulse spans enable-low cycles and is counted once per enabled cycle).
- Reset values: all outputs 0; FSM IDLE; PRBS 15'h7FFF; accumulators 0.
- Reset mid-frame: in-flight pipeline contents are discarded and no oframe_done is issued for that frame.
- Reset has priority over iclkena.

## Configuration
- DEMAPPER_BER_CHECKER_PRBS_EN defined: the PRBS-15 generator is built and imode selects the reference.
- Not defined: no PRBS logic is built, imode is ignored, and the reference is always the index counter (mode 0).

## Test plan
- qam 1..8 and 10, counter mode, error-free LLRs (+/-max), each frame 2**qam symbols back-to-back:
  - one oframe_done per frame, obit_err=0, osym_err=0, osym_cnt=2**qam.
  - e.g. qam=10 gives osym_cnt=1024 on the pulse 2 cycles after the last symbol.
- qam=4, symbol 5 with lanes 0 and 2 flipped, and lane 7 (masked) negative:
  - obit_err=2, osym_err=1, osym_cnt=16.
- qam=6 frame, new isop with qam=3 after 20 symbols:
  - oabort=1, osym_cnt=20, oframe_qam=6.
  - next report has oframe_qam=3, osym_cnt=8, oabort=0.
- isop with iqam=0, and separately iqam=11 (pBITS_MAX=10):
  - oqam_err=1, no oframe_done.
  - a following legal frame still reports correctly.
- With DEMAPPER_BER_CHECKER_PRBS_EN, imode=1, qam=2, LLRs driven from the expected PRBS sequence:
  - errors=0.
  - repeating with the sequence shifted by one symbol gives osym_err>0.
- iclkena toggled 50% across a qam=5 frame, plus ireset pulsed mid-frame:
  - the gated frame reports osym_cnt=32, matching the ungated run.
  - the reset frame produces no report and all outputs read 0.
